// File: rtl/flit_sink_if.sv
// Flit bus driven by the router mux output port (odata/ovalid/ovch) into flit_sink.
interface flit_sink_if #(
    parameter int DATAW = 66,
    parameter int VCHW  = 2
) ();
    logic [DATAW-1:0] idata;
    logic             ivalid;
    logic [VCHW-1:0]  ivch;

    modport master (output idata, ivalid, ivch);
    modport slave  (input  idata, ivalid, ivch);
endinterface

// File: rtl/flit_sink.sv
// Packet receiver/monitor: rebuilds HEAD/DATA*/TAIL framing, reports per-packet results and
// sticky framing errors. Define FLIT_SINK_TOGGLE_EN to enable the payload toggle counter.
module flit_sink #(
    parameter int DATAW = 66,
    parameter int VCHW  = 2,
    parameter int LENW  = 16
) (
    input  logic            clk,
    input  logic            rst_,
    flit_sink_if.slave      flit,
    input  logic            clr,
    output logic            busy,
    output logic            pkt_done,
    output logic [LENW-1:0] pkt_len,
    output logic [31:0]     pkt_dst,
    output logic [VCHW-1:0] pkt_vch,
    output logic [LENW-1:0] pkt_cnt,
    output logic            pkt_err,
    output logic [1:0]      err_code,
    output logic [31:0]     toggle_cnt
);
    typedef enum logic [1:0] {
        T_NONE = 2'b00, T_HEAD = 2'b01, T_TAIL = 2'b10, T_DATA = 2'b11
    } flit_type_e;
    typedef enum logic { IDLE = 1'b0, BODY = 1'b1 } state_e;

    localparam logic [LENW-1:0] LEN_MAX = '1;

    flit_type_e      ftype;
    logic            acc;
    state_e          state_q, state_d;
    logic [LENW-1:0] len_q, len_d, len_inc;
    logic [31:0]     dst_q, dst_d;
    logic [VCHW-1:0] vch_q, vch_d;
    logic            pkt_done_q, pkt_done_d;
    logic [LENW-1:0] pkt_len_q, pkt_len_d;
    logic [31:0]     pkt_dst_q, pkt_dst_d;
    logic [VCHW-1:0] pkt_vch_q, pkt_vch_d;
    logic [LENW-1:0] pkt_cnt_q, pkt_cnt_d;
    logic            pkt_err_q, pkt_err_d;
    logic [1:0]      err_code_q, err_code_d;
    logic            err_set;
    logic [1:0]      err_val;

    assign ftype   = flit_type_e'(flit.idata[DATAW-1:DATAW-2]);
    assign acc     = flit.ivalid && (ftype != T_NONE);
    assign len_inc = (len_q == LEN_MAX) ? len_q : len_q + LENW'(1);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (acc) begin
            case (state_q)
                IDLE:    if (ftype == T_HEAD) state_d = BODY;
                BODY:    if (ftype == T_TAIL) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: every comb output starts from a default so no path can infer a latch.
    always_comb begin
        len_d      = len_q;
        dst_d      = dst_q;
        vch_d      = vch_q;
        pkt_done_d = 1'b0;
        pkt_len_d  = pkt_len_q;
        pkt_dst_d  = pkt_dst_q;
        pkt_vch_d  = pkt_vch_q;
        pkt_cnt_d  = pkt_cnt_q;
        pkt_err_d  = pkt_err_q;
        err_code_d = err_code_q;
        err_set    = 1'b0;
        err_val    = 2'b00;
        if (acc) begin
            if (ftype == T_HEAD) begin
                // A HEAD always opens a fresh packet; inside BODY the open one is dropped.
                len_d = LENW'(1);
                dst_d = flit.idata[31:0];
                vch_d = flit.ivch;
                if (state_q == BODY) begin
                    err_set = 1'b1;
                    err_val = 2'b10;
                end
            end else if (state_q == IDLE) begin
                err_set = 1'b1;
                err_val = 2'b01;
            end else begin
                len_d = len_inc;
                if (flit.ivch != vch_q) begin
                    err_set = 1'b1;
                    err_val = 2'b11;
                end
                if (ftype == T_TAIL) begin
                    pkt_done_d = 1'b1;
                    pkt_len_d  = len_inc;
                    pkt_dst_d  = dst_q;
                    pkt_vch_d  = vch_q;
                    pkt_cnt_d  = (pkt_cnt_q == LEN_MAX) ? pkt_cnt_q : pkt_cnt_q + LENW'(1);
                end
            end
        end
        if (err_set && !pkt_err_q) begin
            pkt_err_d  = 1'b1;
            err_code_d = err_val;
        end
        if (clr) begin
            pkt_cnt_d  = '0;
            pkt_err_d  = 1'b0;
            err_code_d = 2'b00;
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            len_q      <= '0;
            dst_q      <= '0;
            vch_q      <= '0;
            pkt_done_q <= 1'b0;
            pkt_len_q  <= '0;
            pkt_dst_q  <= '0;
            pkt_vch_q  <= '0;
            pkt_cnt_q  <= '0;
            pkt_err_q  <= 1'b0;
            err_code_q <= 2'b00;
        end else begin
            len_q      <= len_d;
            dst_q      <= dst_d;
            vch_q      <= vch_d;
            pkt_done_q <= pkt_done_d;
            pkt_len_q  <= pkt_len_d;
            pkt_dst_q  <= pkt_dst_d;
            pkt_vch_q  <= pkt_vch_d;
            pkt_cnt_q  <= pkt_cnt_d;
            pkt_err_q  <= pkt_err_d;
            err_code_q <= err_code_d;
        end
    end

    assign busy     = (state_q == BODY);
    assign pkt_done = pkt_done_q;
    assign pkt_len  = pkt_len_q;
    assign pkt_dst  = pkt_dst_q;
    assign pkt_vch  = pkt_vch_q;
    assign pkt_cnt  = pkt_cnt_q;
    assign pkt_err  = pkt_err_q;
    assign err_code = err_code_q;

`ifdef FLIT_SINK_TOGGLE_EN
    logic [63:0] prev_q, prev_d;
    logic [31:0] toggle_q, toggle_d;
    logic [32:0] tsum;

    always_comb begin
        prev_d   = prev_q;
        toggle_d = toggle_q;
        tsum     = {1'b0, toggle_q} + 33'($countones(flit.idata[63:0] ^ prev_q));
        if (acc) begin
            toggle_d = tsum[32] ? 32'hFFFF_FFFF : tsum[31:0];
            prev_d   = flit.idata[63:0];
        end
        if (clr) begin
            prev_d   = '0;
            toggle_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            prev_q   <= '0;
            toggle_q <= '0;
        end else begin
            prev_q   <= prev_d;
            toggle_q <= toggle_d;
        end
    end

    assign toggle_cnt = toggle_q;
`else
    assign toggle_cnt = '0;
`endif
endmodule

// File: tb/tb_flit_sink.sv
// Directed self-checking bench for flit_sink: framing, errors, clr, reset and toggle counting.
module tb_flit_sink;
    localparam logic [1:0] T_NONE = 2'b00, T_HEAD = 2'b01, T_TAIL = 2'b10, T_DATA = 2'b11;

    logic        clk = 1'b0;
    logic        rst_ = 1'b0;
    logic        clr = 1'b0;
    logic        busy, pkt_done, pkt_err;
    logic [15:0] pkt_len, pkt_cnt;
    logic [31:0] pkt_dst, toggle_cnt;
    logic [1:0]  pkt_vch, err_code;

    int n_cmp = 0;
    int n_mis = 0;
    int done_cnt = 0;
    int d0;

    flit_sink_if #(.DATAW(66), .VCHW(2)) fif ();

    flit_sink #(.DATAW(66), .VCHW(2), .LENW(16)) dut (
        .clk(clk), .rst_(rst_), .flit(fif), .clr(clr),
        .busy(busy), .pkt_done(pkt_done), .pkt_len(pkt_len), .pkt_dst(pkt_dst),
        .pkt_vch(pkt_vch), .pkt_cnt(pkt_cnt), .pkt_err(pkt_err), .err_code(err_code),
        .toggle_cnt(toggle_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (pkt_done === 1'b1) done_cnt++;

    task automatic send(input logic [1:0] t, input logic [63:0] p, input logic [1:0] v);
        fif.ivalid = 1'b1;
        fif.idata  = {t, p};
        fif.ivch   = v;
        @(posedge clk); #1;
        fif.ivalid = 1'b0;
        fif.idata  = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic clr_pulse();
        clr = 1'b1;
        idle(1);
        clr = 1'b0;
    endtask

    task automatic send_pkt(input logic [31:0] dst, input logic [1:0] v, input int ndata);
        send(T_HEAD, {32'h0, dst}, v);
        for (int i = 0; i < ndata; i++) send(T_DATA, 64'(i), v);
        send(T_TAIL, 64'h0, v);
    endtask

    task automatic test_reset();
        #12;
        n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL reset_busy got %0h want 0", busy); end
        n_cmp++; if (pkt_done !== 1'b0) begin n_mis++; $display("FAIL reset_done got %0h want 0", pkt_done); end
        n_cmp++; if (pkt_len !== 16'd0) begin n_mis++; $display("FAIL reset_len got %0d want 0", pkt_len); end
        n_cmp++; if (pkt_dst !== 32'd0) begin n_mis++; $display("FAIL reset_dst got %0h want 0", pkt_dst); end
        n_cmp++; if (pkt_cnt !== 16'd0) begin n_mis++; $display("FAIL reset_cnt got %0d want 0", pkt_cnt); end
        n_cmp++; if (pkt_err !== 1'b0 || err_code !== 2'b00) begin n_mis++; $display("FAIL reset_err got %0h/%0h want 0/0", pkt_err, err_code); end
        n_cmp++; if (toggle_cnt !== 32'd0) begin n_mis++; $display("FAIL reset_toggle got %0d want 0", toggle_cnt); end
        @(posedge clk); #1;
        rst_ = 1'b1;
        idle(1);
    endtask

    task automatic test_single();
        d0 = done_cnt;
        send(T_HEAD, 64'h9, 2'd0);
        n_cmp++; if (busy !== 1'b1) begin n_mis++; $display("FAIL single_busy_rise got %0h want 1", busy); end
        for (int i = 0; i < 20; i++) send(T_DATA, 64'(i), 2'd0);
        n_cmp++; if (pkt_done !== 1'b0) begin n_mis++; $display("FAIL single_early_done got %0h want 0", pkt_done); end
        send(T_TAIL, 64'h0, 2'd0);
        n_cmp++; if (pkt_done !== 1'b1) begin n_mis++; $display("FAIL single_done got %0h want 1", pkt_done); end
        n_cmp++; if (pkt_len !== 16'd22) begin n_mis++; $display("FAIL single_len got %0d want 22", pkt_len); end
        n_cmp++; if (pkt_dst !== 32'h9) begin n_mis++; $display("FAIL single_dst got %0h want 9", pkt_dst); end
        n_cmp++; if (pkt_vch !== 2'd0) begin n_mis++; $display("FAIL single_vch got %0d want 0", pkt_vch); end
        n_cmp++; if (pkt_cnt !== 16'd1) begin n_mis++; $display("FAIL single_cnt got %0d want 1", pkt_cnt); end
        n_cmp++; if (pkt_err !== 1'b0) begin n_mis++; $display("FAIL single_err got %0h want 0", pkt_err); end
        n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL single_busy_fall got %0h want 0", busy); end
        idle(2);
        n_cmp++; if (pkt_done !== 1'b0) begin n_mis++; $display("FAIL single_done_fall got %0h want 0", pkt_done); end
        n_cmp++; if (done_cnt - d0 !== 1) begin n_mis++; $display("FAIL single_pulses got %0d want 1", done_cnt - d0); end
        n_cmp++; if (pkt_len !== 16'd22) begin n_mis++; $display("FAIL single_len_hold got %0d want 22", pkt_len); end
    endtask

    task automatic test_stream();
        clr_pulse();
        d0 = done_cnt;
        for (int k = 0; k < 10; k++) begin
            send_pkt(32'(k), 2'(k % 4), 20);
            idle(7);
        end
        n_cmp++; if (pkt_cnt !== 16'd10) begin n_mis++; $display("FAIL gap_cnt got %0d want 10", pkt_cnt); end
        n_cmp++; if (pkt_err !== 1'b0) begin n_mis++; $display("FAIL gap_err got %0h want 0", pkt_err); end
        n_cmp++; if (done_cnt - d0 !== 10) begin n_mis++; $display("FAIL gap_pulses got %0d want 10", done_cnt - d0); end
        clr_pulse();
        n_cmp++; if (pkt_cnt !== 16'd0) begin n_mis++; $display("FAIL clr_cnt got %0d want 0", pkt_cnt); end
        d0 = done_cnt;
        for (int k = 0; k < 10; k++) send_pkt(32'(k + 100), 2'(k % 4), 20);
        n_cmp++; if (pkt_cnt !== 16'd10) begin n_mis++; $display("FAIL b2b_cnt got %0d want 10", pkt_cnt); end
        n_cmp++; if (pkt_err !== 1'b0) begin n_mis++; $display("FAIL b2b_err got %0h want 0", pkt_err); end
        n_cmp++; if (pkt_dst !== 32'd109 || pkt_vch !== 2'd1) begin n_mis++; $display("FAIL b2b_last got %0d/%0d want 109/1", pkt_dst, pkt_vch); end
        idle(1);
        n_cmp++; if (done_cnt - d0 !== 10) begin n_mis++; $display("FAIL b2b_pulses got %0d want 10", done_cnt - d0); end
    endtask

    task automatic test_errors();
        clr_pulse();
        clr = 1'b1;
        send(T_DATA, 64'h0, 2'd0);
        clr = 1'b0;
        n_cmp++; if (pkt_err !== 1'b0) begin n_mis++; $display("FAIL clr_vs_err got %0h want 0", pkt_err); end
        d0 = done_cnt;
        send(T_DATA, 64'h0, 2'd0);
        n_cmp++; if (pkt_err !== 1'b1 || err_code !== 2'b01) begin n_mis++; $display("FAIL err01 got %0h/%0h want 1/1", pkt_err, err_code); end
        n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL err01_busy got %0h want 0", busy); end
        send(T_HEAD, 64'h1, 2'd0);
        send(T_DATA, 64'h0, 2'd0);
        send(T_HEAD, 64'h2, 2'd0);
        n_cmp++; if (err_code !== 2'b01 || busy !== 1'b1) begin n_mis++; $display("FAIL err_keep10 got %0h/%0h want 1/1", err_code, busy); end
        send(T_DATA, 64'h0, 2'd1);
        n_cmp++; if (err_code !== 2'b01) begin n_mis++; $display("FAIL err_keep11 got %0h want 1", err_code); end
        send(T_TAIL, 64'h0, 2'd0);
        n_cmp++; if (pkt_len !== 16'd3 || pkt_dst !== 32'h2) begin n_mis++; $display("FAIL restart_pkt got %0d/%0h want 3/2", pkt_len, pkt_dst); end
        idle(1);
        n_cmp++; if (done_cnt - d0 !== 1) begin n_mis++; $display("FAIL dropped_pulses got %0d want 1", done_cnt - d0); end
        clr_pulse();
        n_cmp++; if (pkt_err !== 1'b0 || err_code !== 2'b00) begin n_mis++; $display("FAIL clr_err got %0h/%0h want 0/0", pkt_err, err_code); end
        n_cmp++; if (pkt_len !== 16'd3) begin n_mis++; $display("FAIL clr_keeps_len got %0d want 3", pkt_len); end
        send(T_HEAD, 64'h3, 2'd0);
        send(T_HEAD, 64'h4, 2'd1);
        n_cmp++; if (err_code !== 2'b10) begin n_mis++; $display("FAIL err10_prio got %0h want 2", err_code); end
        send(T_TAIL, 64'h0, 2'd1);
        n_cmp++; if (pkt_len !== 16'd2 || pkt_dst !== 32'h4 || pkt_vch !== 2'd1) begin n_mis++; $display("FAIL err10_pkt got %0d/%0h/%0d want 2/4/1", pkt_len, pkt_dst, pkt_vch); end
        clr_pulse();
        send(T_HEAD, 64'h5, 2'd0);
        send(T_DATA, 64'h0, 2'd2);
        n_cmp++; if (pkt_err !== 1'b1 || err_code !== 2'b11) begin n_mis++; $display("FAIL err11 got %0h/%0h want 1/3", pkt_err, err_code); end
        send(T_TAIL, 64'h0, 2'd0);
        n_cmp++; if (pkt_len !== 16'd3 || pkt_done !== 1'b1) begin n_mis++; $display("FAIL err11_pkt got %0d/%0h want 3/1", pkt_len, pkt_done); end
        idle(1);
    endtask

    task automatic test_toggle();
        logic [31:0] exp_first, exp_total;
        logic [63:0] pat [4];
        pat[0] = {32{2'b01}}; pat[1] = {32{2'b11}}; pat[2] = {32{2'b10}}; pat[3] = 64'h0;
`ifdef FLIT_SINK_TOGGLE_EN
        exp_first = 32'd32; exp_total = 32'd640;
`else
        exp_first = 32'd0;  exp_total = 32'd0;
`endif
        clr_pulse();
        n_cmp++; if (toggle_cnt !== 32'd0) begin n_mis++; $display("FAIL toggle_clr got %0d want 0", toggle_cnt); end
        send(T_HEAD, 64'h0, 2'd0);
        n_cmp++; if (toggle_cnt !== 32'd0) begin n_mis++; $display("FAIL toggle_head got %0d want 0", toggle_cnt); end
        send(T_NONE, 64'hFFFF_FFFF_FFFF_FFFF, 2'd0);
        n_cmp++; if (toggle_cnt !== 32'd0 || busy !== 1'b1) begin n_mis++; $display("FAIL none_ignored got %0d/%0h want 0/1", toggle_cnt, busy); end
        for (int i = 0; i < 20; i++) begin
            send(T_DATA, pat[i % 4], 2'd0);
            if (i == 0) begin
                n_cmp++; if (toggle_cnt !== exp_first) begin n_mis++; $display("FAIL toggle_first got %0d want %0d", toggle_cnt, exp_first); end
            end
        end
        send(T_TAIL, 64'h0, 2'd0);
        n_cmp++; if (toggle_cnt !== exp_total) begin n_mis++; $display("FAIL toggle_total got %0d want %0d", toggle_cnt, exp_total); end
        n_cmp++; if (pkt_len !== 16'd22) begin n_mis++; $display("FAIL toggle_len got %0d want 22", pkt_len); end
        clr_pulse();
        n_cmp++; if (toggle_cnt !== 32'd0) begin n_mis++; $display("FAIL toggle_clr2 got %0d want 0", toggle_cnt); end
    endtask

    task automatic test_reset_mid();
        send(T_DATA, 64'h0, 2'd0);
        send(T_HEAD, 64'h7, 2'd3);
        send(T_DATA, 64'h1234, 2'd3);
        rst_ = 1'b0;
        #2;
        n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL rstmid_busy got %0h want 0", busy); end
        n_cmp++; if (pkt_len !== 16'd0 || pkt_cnt !== 16'd0) begin n_mis++; $display("FAIL rstmid_len_cnt got %0d/%0d want 0/0", pkt_len, pkt_cnt); end
        n_cmp++; if (pkt_err !== 1'b0 || err_code !== 2'b00) begin n_mis++; $display("FAIL rstmid_err got %0h/%0h want 0/0", pkt_err, err_code); end
        n_cmp++; if (pkt_dst !== 32'd0 || pkt_vch !== 2'd0 || toggle_cnt !== 32'd0) begin n_mis++; $display("FAIL rstmid_other got %0h/%0d/%0d want 0/0/0", pkt_dst, pkt_vch, toggle_cnt); end
        @(posedge clk); #1;
        rst_ = 1'b1;
        idle(1);
        send_pkt(32'hAB, 2'd2, 1);
        n_cmp++; if (pkt_len !== 16'd3 || pkt_cnt !== 16'd1) begin n_mis++; $display("FAIL rstmid_pkt got %0d/%0d want 3/1", pkt_len, pkt_cnt); end
        n_cmp++; if (pkt_dst !== 32'hAB || pkt_vch !== 2'd2 || pkt_err !== 1'b0) begin n_mis++; $display("FAIL rstmid_dst got %0h/%0d/%0h want ab/2/0", pkt_dst, pkt_vch, pkt_err); end
    endtask

    task automatic test_clr_tail();
        send(T_HEAD, 64'h33, 2'd1);
        send(T_DATA, 64'h0, 2'd1);
        clr = 1'b1;
        send(T_TAIL, 64'h0, 2'd1);
        clr = 1'b0;
        n_cmp++; if (pkt_done !== 1'b1) begin n_mis++; $display("FAIL clrtail_done got %0h want 1", pkt_done); end
        n_cmp++; if (pkt_cnt !== 16'd0) begin n_mis++; $display("FAIL clrtail_cnt got %0d want 0", pkt_cnt); end
        n_cmp++; if (pkt_len !== 16'd3 || pkt_dst !== 32'h33) begin n_mis++; $display("FAIL clrtail_pkt got %0d/%0h want 3/33", pkt_len, pkt_dst); end
    endtask

    initial begin
        fif.ivalid = 1'b0;
        fif.idata  = '0;
        fif.ivch   = '0;
        test_reset();
        test_single();
        test_stream();
        test_errors();
        test_toggle();
        test_reset_mid();
        test_clr_tail();
        idle(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule

// File: doc/flit_sink.md
# flit_sink

Packet receiver and monitor for the mux output port in the router characterization benches. It samples `{type, payload}` flits from `odata/ovalid/ovch`, rebuilds packet framing (HEAD, DATA*, TAIL) with a two-state FSM, and reports per-packet length, destination and virtual channel. It also keeps sticky framing-error flags, a packet counter and an optional payload toggle counter, so a bench can self-check traffic and measure switching activity without post-processing the dump.

## Interface
- `DATAW`, 66, flit width: `[DATAW-1:DATAW-2]` is the type, `[63:0]` is the payload
- `VCHW`, 2, virtual-channel id width
- `LENW`, 16, width of the length and packet counters

- `clk`  in  1  clock, all state on rising edge
- `rst_`  in  1  asynchronous, active-low reset
- `idata`  in  DATAW  flit from mux `odata`
- `ivalid`  in  1  flit valid (mux `ovalid`)
- `ivch`  in  VCHW  flit VC (mux `ovch`)
- `clr`  in  1  synchronous clear of statistics and error flags
- `busy`  out  1  FSM in BODY
- `pkt_done`  out  1  one-cycle pulse, packet completed
- `pkt_len`  out  LENW  flits in last completed packet, HEAD and TAIL included
- `pkt_dst`  out  32  `idata[31:0]` of that packet's HEAD
- `pkt_vch`  out  VCHW  VC of that packet's HEAD
- `pkt_cnt`  out  LENW  completed packets since reset/clr
- `pkt_err`  out  1  sticky: any framing error seen
- `err_code`  out  2  sticky code of the first error: 01 body/tail with no head, 10 head inside packet, 11 VC changed inside packet
- `toggle_cnt`  out  32  accumulated payload bit toggles

## Operation
- Type encodings: NONE=2'b00, HEAD=2'b01, TAIL=2'b10, DATA=2'b11.
- A flit is accepted only when `ivalid`=1. A valid flit of type NONE is ignored: no state change, no count, no toggle update.
- IDLE:
  - HEAD → BODY; latch dst and vch; length counter = 1.
  - DATA or TAIL → error 01; stay in IDLE.
- BODY:
  - DATA → length +1.
  - TAIL → length +1; load `pkt_len/pkt_dst/pkt_vch`; pulse `pkt_done`; `pkt_cnt` +1; go to IDLE.
  - HEAD → error 10; the open packet is dropped with no `pkt_done`; the new packet restarts with length 1, new dst and vch.
  - Any counted flit whose `ivch` differs from the latched vch → error 11. The flit is still processed normally.
- Length and `pkt_cnt` saturate at all-ones and do not wrap.
- Error flags: `err_code` is written only while `pkt_err`=0, so the first error is kept. If two conditions occur in the same cycle (HEAD on a new VC in BODY), code 10 takes priority.
- `clr` zeroes `pkt_cnt`, `toggle_cnt`, `pkt_err`, `err_code` and the previous-payload register. It does not change the FSM, the open length counter or the `pkt_*` result registers. When `clr` coincides with a TAIL, `pkt_done` still pulses and `pkt_cnt` ends at 0, because `clr` wins. When `clr` coincides with an error, `clr` wins.

## Timing
- Reset values: `busy`=0, `pkt_done`=0, `pkt_len`=0, `pkt_dst`=0, `pkt_vch`=0, `pkt_cnt`=0, `pkt_err`=0, `err_code`=0, `toggle_cnt`=0; FSM in IDLE.
- All outputs are registered. Latency is 1 cycle: a TAIL sampled at edge N gives `pkt_done`=1 for the cycle after edge N, with `pkt_len/dst/vch` valid at the same time and held until the next completion.
- `busy` rises the cycle after the HEAD edge and falls the cycle after the TAIL edge.
- Back-to-back packets (TAIL at N, HEAD at N+1) are supported with no bubble.
- Flits may arrive every cycle. There is no backpressure: the block always accepts.
- Reset asserted mid-packet immediately returns everything to reset values; the partial packet is lost.

## Configuration
- `FLIT_SINK_TOGGLE_EN` defined:
  - Each accepted non-NONE flit adds popcount(`idata[63:0]` XOR previous accepted payload) to `toggle_cnt`, saturating at 2^32−1.
  - The previous-payload register then loads the current payload. It resets to 0.
- Undefined: no previous-payload register and no popcount logic; `toggle_cnt` is tied to 0.

## Test plan
- HEAD dst 0x09 on VC 0, 20 DATA, TAIL → one `pkt_done` pulse, `pkt_len`=22, `pkt_dst`=0x09, `pkt_vch`=0, `pkt_cnt`=1, `pkt_err`=0.
- 10 packets of HEAD+20 DATA+TAIL with 7 idle cycles between them, then the same traffic back-to-back with no gaps → `pkt_cnt`=10 after each half (`clr` between the halves), no errors.
- DATA flit while IDLE, then HEAD in BODY, then a VC change → `pkt_err`=1 and `err_code`=01, which is kept after the later errors; the dropped packet produces no `pkt_done`.
- With `FLIT_SINK_TOGGLE_EN`: HEAD payload 0, then DATA payloads repeating {32{2'b01}}, {32{2'b11}}, {32{2'b10}}, 0 → each flit adds 32, except the first (HEAD → 0x5555…, also +32). 20 DATA flits give `toggle_cnt`=640. Without the macro, `toggle_cnt`=0.
- `rst_` pulsed low mid-packet, then a full 3-flit packet → all outputs at reset values during reset, then `pkt_len`=3 and `pkt_cnt`=1.
- `clr` in the same cycle as a TAIL → `pkt_done`=1 and `pkt_cnt`=0 on the following cycle.
